wait_merge_n: RTL

WAIT_MERGE_N -- requirements
Module: wait_merge_n

---
 rtl/wait_merge_pkg.sv | 21 ++
 rtl/wait_merge_n_if.sv | 35 +++
 rtl/wm_pending_ctr.sv | 39 +++
 rtl/wait_merge_n.sv | 74 +++++++
 4 files changed

// File: rtl/wait_merge_pkg.sv
// Shared types and constants for the wait_merge_n join.
// Holds the FSM state type, free-mode encodings and a width helper.
package wait_merge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int FREE_BCAST = 0;
  localparam int FREE_PERCH = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wait_merge_n_if.sv
// Drive/free handshake bundle between upstream channels,
// the join and the downstream consumer.
interface wait_merge_n_if #(
  parameter int NCH = 4
) ();

  logic [NCH-1:0] i_drive;
  logic [NCH-1:0] i_en_mask;
  logic [NCH-1:0] o_free;
  logic           o_driveNext;
  logic           i_freeNext;
  logic           o_busy;
  logic [NCH-1:0] o_overflow;

  modport master (
    output i_drive,
    output i_en_mask,
    output i_freeNext,
    input  o_free,
    input  o_driveNext,
    input  o_busy,
    input  o_overflow
  );

  modport slave (
    input  i_drive,
    input  i_en_mask,
    input  i_freeNext,
    output o_free,
    output o_driveNext,
    output o_busy,
    output o_overflow
  );

endinterface

// File: rtl/wm_pending_ctr.sv
// One channel's pending-token counter, saturating at DEPTH,
// with a sticky flag for tokens dropped while full.
module wm_pending_ctr
  import wait_merge_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic drive,
  input  logic dec,
  output logic ready,
  output logic overflow
);

  localparam int CW = clog2(DEPTH + 1);
  localparam logic [CW-1:0] MAX = CW'(DEPTH);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      case ({drive, dec})
        2'b10: begin
          if (cnt == MAX) overflow <= 1'b1;
          else            cnt      <= cnt + CW'(1);
        end
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  assign ready = (cnt != '0);

endmodule

// File: rtl/wait_merge_n.sv
// N-way drive join: fires one merged drive once every enabled
// channel holds a token, then waits for the downstream free.
module wait_merge_n
  import wait_merge_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DEPTH     = 2,
  parameter int FREE_MODE = FREE_BCAST
) (
  input logic          clk,
  input logic          rst,
  wait_merge_n_if.slave bus
);

  state_t         state;
  logic [NCH-1:0] drv_acc;
  logic [NCH-1:0] ready;
  logic [NCH-1:0] dec;
  logic [NCH-1:0] ovf;
  logic           all_ready;
  logic           fire_go;

  assign drv_acc   = bus.i_drive & bus.i_en_mask;
  assign all_ready = (|bus.i_en_mask) &&
                     (&(ready | ~bus.i_en_mask));
  assign fire_go   = (state == IDLE) && all_ready;
  assign dec       = fire_go ? bus.i_en_mask : '0;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    wm_pending_ctr #(
      .DEPTH(DEPTH)
    ) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .drive   (drv_acc[k]),
      .dec     (dec[k]),
      .ready   (ready[k]),
      .overflow(ovf[k])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (all_ready) state <= FIRE;
        FIRE: state <= bus.i_freeNext ? IDLE : WAIT;
        WAIT: if (bus.i_freeNext) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_driveNext = (state == FIRE);
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_overflow  = ovf;

  if (FREE_MODE == FREE_PERCH) begin : g_free_perch
    logic [NCH-1:0] free_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) free_q <= '0;
      else      free_q <= dec;
    end

    assign bus.o_free = free_q;
  end else begin : g_free_bcast
    // Gated by rst so o_free is quiet while reset is held.
    assign bus.o_free = {NCH{bus.i_freeNext & rst}} &
                        bus.i_en_mask;
  end

endmodule
